// File: rtl/c_wf_diag_ctrl.sv
// Priority-diagonal controller for an N x N wavefront allocator: round-robin
// advance of a one-hot diagonal, optional empty-diagonal skip, starvation override.
module c_wf_diag_ctrl #(
  parameter int num_ports        = 8,
  parameter bit skip_empty_diags = 1'b0,
  parameter int starve_limit     = 15,
  parameter int cnt_width        = $clog2(starve_limit + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           active,
  input  logic                           update,
  input  logic [0:num_ports*num_ports-1] req,
  input  logic [0:num_ports*num_ports-1] gnt,
  output logic [0:num_ports-1]           prio_diag,
  output logic [0:num_ports-1]           diag_req,
  output logic                           starve_force,
  output logic                           starve_any
);

  localparam logic [cnt_width-1:0]   LIMIT    = cnt_width'(starve_limit);
  localparam logic [0:num_ports-1]   PRIO_RST = {1'b1, {(num_ports-1){1'b0}}};

  logic [0:num_ports-1] prio_q, prio_d;
  logic                 force_q, force_d;
  logic [cnt_width-1:0] age_q [num_ports];
  logic [cnt_width-1:0] age_d [num_ports];

  logic [0:num_ports-1] diag_gnt, sat, rot, starve_pick, skip_pick;
  logic                 starve_hit, skip_hit, commit;

  assign commit       = active & update;
  assign prio_diag    = prio_q;
  assign starve_force = force_q;
  assign starve_any   = |sat;

  // Cell (i,j) lies on diagonal (i+j) mod N, so diagonal d holds (i, (d-i) mod N).
  always_comb begin
    diag_req = '0;
    diag_gnt = '0;
    for (int d = 0; d < num_ports; d++) begin
      sat[d] = (age_q[d] == LIMIT);
      for (int i = 0; i < num_ports; i++) begin
        diag_req[d] = diag_req[d] | req[i*num_ports + (d - i + num_ports) % num_ports];
        diag_gnt[d] = diag_gnt[d] | gnt[i*num_ports + (d - i + num_ports) % num_ports];
      end
    end
  end

  // Circular searches start one past the current diagonal and end on it;
  // offset k is the outer loop so the first hit is the nearest one.
  always_comb begin
    rot         = '0;
    starve_pick = '0;
    skip_pick   = '0;
    starve_hit  = 1'b0;
    skip_hit    = 1'b0;
    for (int d = 0; d < num_ports; d++) begin
      rot[(d + 1) % num_ports] = prio_q[d];
    end
    for (int k = 1; k <= num_ports; k++) begin
      for (int d = 0; d < num_ports; d++) begin
        if (prio_q[d] && !starve_hit && sat[(d + k) % num_ports]) begin
          starve_hit = 1'b1;
          starve_pick[(d + k) % num_ports] = 1'b1;
        end
        if (prio_q[d] && !skip_hit && diag_req[(d + k) % num_ports]) begin
          skip_hit = 1'b1;
          skip_pick[(d + k) % num_ports] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    prio_d  = prio_q;
    force_d = force_q;
    for (int d = 0; d < num_ports; d++) begin
      age_d[d] = age_q[d];
    end
    if (commit) begin
      if (starve_hit) begin
        prio_d  = starve_pick;
        force_d = 1'b1;
      end else if (skip_empty_diags && skip_hit) begin
        prio_d  = skip_pick;
        force_d = 1'b0;
      end else begin
        prio_d  = rot;
        force_d = 1'b0;
      end
      for (int d = 0; d < num_ports; d++) begin
        if (diag_req[d] && !diag_gnt[d]) begin
          age_d[d] = sat[d] ? LIMIT : age_q[d] + 1'b1;
        end else begin
          age_d[d] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q  <= PRIO_RST;
      force_q <= 1'b0;
      for (int d = 0; d < num_ports; d++) begin
        age_q[d] <= '0;
      end
    end else begin
      prio_q  <= prio_d;
      force_q <= force_d;
      for (int d = 0; d < num_ports; d++) begin
        age_q[d] <= age_d[d];
      end
    end
  end

endmodule

// File: tb/tb_c_wf_diag_ctrl.sv
// Bench for c_wf_diag_ctrl: two N=4 instances (plain rotate and skip-empty)
// against an index-based model, directed literal scenarios, then random traffic.
module tb_c_wf_diag_ctrl;

  localparam int N   = 4;
  localparam int LIM = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             active, update;
  logic [0:N*N-1]   req, gnt;
  logic [0:N-1]     prio_a, dreq_a, prio_b, dreq_b;
  logic             sf_a, sa_a, sf_b, sa_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  c_wf_diag_ctrl #(.num_ports(N), .skip_empty_diags(1'b0), .starve_limit(LIM)) dut_a (
    .clk(clk), .reset(reset), .active(active), .update(update), .req(req), .gnt(gnt),
    .prio_diag(prio_a), .diag_req(dreq_a), .starve_force(sf_a), .starve_any(sa_a));

  c_wf_diag_ctrl #(.num_ports(N), .skip_empty_diags(1'b1), .starve_limit(LIM)) dut_b (
    .clk(clk), .reset(reset), .active(active), .update(update), .req(req), .gnt(gnt),
    .prio_diag(prio_b), .diag_req(dreq_b), .starve_force(sf_b), .starve_any(sa_b));

  // ---------------- reference model (instance 0: rotate, 1: skip-empty)
  int  m_prio [2] = '{0, 0};
  bit  m_sf   [2] = '{1'b0, 1'b0};
  int  m_age  [2][N];
  int  n_prio [2];
  bit  n_sf   [2];
  int  n_age  [2][N];
  int  pick;
  logic [0:N-1] m_dr, m_dg;

  function automatic logic [0:N-1] diag_or(input logic [0:N*N-1] m);
    logic [0:N-1] r;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (m[i*N+j]) r[(i+j)%N] = 1'b1;
    return r;
  endfunction

  function automatic logic [0:N-1] onehot(input int i);
    logic [0:N-1] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic bit any_sat(input int m);
    bit s;
    s = 1'b0;
    for (int d = 0; d < N; d++) if (m_age[m][d] == LIM) s = 1'b1;
    return s;
  endfunction

  always_comb begin
    m_dr = diag_or(req);
    m_dg = diag_or(gnt);
    pick = -1;
    for (int m = 0; m < 2; m++) begin
      n_prio[m] = (m_prio[m] + 1) % N;
      n_sf[m]   = 1'b0;
      pick      = -1;
      for (int k = 1; k <= N; k++)
        if (pick < 0 && m_age[m][(m_prio[m]+k)%N] == LIM) pick = (m_prio[m] + k) % N;
      if (pick >= 0) begin
        n_prio[m] = pick;
        n_sf[m]   = 1'b1;
      end else if (m == 1 && m_dr != '0) begin
        for (int k = 1; k <= N; k++)
          if (pick < 0 && m_dr[(m_prio[m]+k)%N]) pick = (m_prio[m] + k) % N;
        n_prio[m] = pick;
      end
      for (int d = 0; d < N; d++)
        n_age[m][d] = (m_dr[d] && !m_dg[d]) ? ((m_age[m][d] < LIM) ? m_age[m][d] + 1 : LIM) : 0;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        m_prio[m] <= 0;
        m_sf[m]   <= 1'b0;
        for (int d = 0; d < N; d++) m_age[m][d] <= 0;
      end
    end else if (active && update) begin
      for (int m = 0; m < 2; m++) begin
        m_prio[m] <= n_prio[m];
        m_sf[m]   <= n_sf[m];
        for (int d = 0; d < N; d++) m_age[m][d] <= n_age[m][d];
      end
    end
  end

  // ---------------- checking
  task automatic chk_v(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk_v("cmp_prio_a", prio_a, onehot(m_prio[0]));
    chk_v("cmp_prio_b", prio_b, onehot(m_prio[1]));
    chk_b("cmp_sf_a", sf_a, m_sf[0]);
    chk_b("cmp_sf_b", sf_b, m_sf[1]);
    chk_v("cmp_dreq_a", dreq_a, diag_or(req));
    chk_v("cmp_dreq_b", dreq_b, diag_or(req));
    chk_b("cmp_sa_a", sa_a, any_sat(0));
    chk_b("cmp_sa_b", sa_b, any_sat(1));
  end

  // ---------------- driver tasks
  task automatic cyc(input logic a, input logic u, input logic [0:N*N-1] r, input logic [0:N*N-1] g);
    active = a;
    update = u;
    req    = r;
    gnt    = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    active = 1'b0;
    update = 1'b0;
    req    = '0;
    gnt    = '0;
    reset  = 1'b0;
    @(posedge clk);
    #1;
    reset  = 1'b1;
  endtask

  logic [0:N*N-1] r_v, g_v;
  logic [0:N-1]   seq_exp [4];
  int             dens;

  initial begin
    reset  = 1'b0;
    active = 1'b0;
    update = 1'b0;
    req    = '0;
    gnt    = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state, then plain rotation with no requests
    chk_v("rst_prio_a", prio_a, 4'b1000);
    chk_v("rst_prio_b", prio_b, 4'b1000);
    chk_b("rst_sf_a", sf_a, 1'b0);
    chk_b("rst_sa_a", sa_a, 1'b0);
    seq_exp = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, '0, '0);
      chk_v("rot_prio_a", prio_a, seq_exp[i]);
      chk_v("rot_prio_b", prio_b, seq_exp[i]);
      chk_b("rot_sf_a", sf_a, 1'b0);
    end

    // Skip-empty: only cell (1,2) requests -> diagonal 3, then hold
    do_reset();
    r_v = '0;
    r_v[6] = 1'b1;
    cyc(1'b1, 1'b1, r_v, '0);
    chk_v("skip_first_b", prio_b, 4'b0001);
    chk_b("skip_first_sf_b", sf_b, 1'b0);
    cyc(1'b1, 1'b1, r_v, '0);
    chk_v("skip_hold_b", prio_b, 4'b0001);
    chk_b("skip_sa_early_b", sa_b, 1'b0);
    cyc(1'b1, 1'b1, r_v, '0);
    chk_v("skip_hold2_b", prio_b, 4'b0001);
    chk_b("skip_sa_b", sa_b, 1'b1);
    chk_v("noskip_prio_a", prio_a, 4'b0001);

    // Updates while inactive are ignored
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, '1, '0);
      chk_v("inact_prio_a", prio_a, 4'b1000);
      chk_v("inact_prio_b", prio_b, 4'b1000);
    end
    cyc(1'b1, 1'b1, '0, '0);
    chk_v("inact_step_a", prio_a, 4'b0100);
    chk_v("inact_step_b", prio_b, 4'b0100);
    chk_b("inact_sf_a", sf_a, 1'b0);

    // Starvation of diagonal 2 (cell (0,2)), never granted, then granted
    do_reset();
    r_v = '0;
    r_v[2] = 1'b1;
    seq_exp = '{4'b0100, 4'b0010, 4'b0001, 4'b0010};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, r_v, '0);
      chk_v("starve_prio_a", prio_a, seq_exp[i]);
      chk_v("starve_prio_b", prio_b, 4'b0010);
      chk_b("starve_sf_a", sf_a, i == 3);
      chk_b("starve_sf_b", sf_b, i == 3);
      chk_b("starve_sa_a", sa_a, i >= 2);
    end
    cyc(1'b1, 1'b1, r_v, r_v);
    chk_v("grant_prio_a", prio_a, 4'b0010);
    chk_b("grant_sf_a", sf_a, 1'b1);
    chk_b("grant_sa_a", sa_a, 1'b0);
    cyc(1'b1, 1'b1, '0, '0);
    chk_v("after_prio_a", prio_a, 4'b0001);
    chk_v("after_prio_b", prio_b, 4'b0001);
    chk_b("after_sf_a", sf_a, 1'b0);
    chk_b("after_sf_b", sf_b, 1'b0);

    // Diagonals 1 and 3 both saturated with current diagonal 2
    do_reset();
    repeat (3) cyc(1'b1, 1'b1, '0, '0);
    chk_v("two_start_a", prio_a, 4'b0001);
    r_v = '0;
    r_v[1] = 1'b1;
    r_v[3] = 1'b1;
    repeat (3) cyc(1'b1, 1'b1, r_v, '0);
    chk_v("two_cur_a", prio_a, 4'b0010);
    chk_b("two_sa_a", sa_a, 1'b1);
    cyc(1'b1, 1'b1, r_v, '0);
    chk_v("two_first_a", prio_a, 4'b0001);
    chk_b("two_first_sf_a", sf_a, 1'b1);
    cyc(1'b1, 1'b1, r_v, '0);
    chk_v("two_second_a", prio_a, 4'b0100);
    chk_b("two_second_sf_a", sf_a, 1'b1);

    // Asynchronous reset between edges with nonzero counters
    do_reset();
    r_v = '0;
    r_v[2] = 1'b1;
    repeat (2) cyc(1'b1, 1'b1, r_v, '0);
    chk_v("arst_pre_a", prio_a, 4'b0010);
    #2;
    reset = 1'b0;
    #1;
    chk_v("arst_prio_a", prio_a, 4'b1000);
    chk_v("arst_prio_b", prio_b, 4'b1000);
    chk_b("arst_sf_a", sf_a, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) cyc(1'b1, 1'b1, r_v, '0);
    chk_b("arst_cnt_clear_a", sa_a, 1'b0);
    cyc(1'b1, 1'b1, r_v, '0);
    chk_b("arst_cnt_sat_a", sa_a, 1'b1);

    // Random traffic against the model
    for (int it = 0; it < 3000; it++) begin
      dens = 1 + (it / 300) % 6;
      for (int b = 0; b < N*N; b++) begin
        r_v[b] = ($urandom_range(0, dens) == 0);
        g_v[b] = r_v[b] && ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 9) == 0) begin
        r_v = '0;
        g_v = '0;
      end
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, r_v, g_v);
      if ($urandom_range(0, 299) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        chk_v("rnd_arst_a", prio_a, 4'b1000);
        chk_v("rnd_arst_b", prio_b, 4'b1000);
        @(posedge clk);
        #1;
        reset = 1'b1;
      end
    end

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/c_wf_diag_ctrl.md
Name: c_wf_diag_ctrl

Overview:
Priority-diagonal controller for an N x N wavefront allocator. Holds the one-hot priority diagonal and advances it on each update. Advancement is round-robin, optionally skips empty diagonals, and forces a starving diagonal to top priority. Sits beside the allocator core in router VC/switch allocation: requests and combined grants in, prio_diag out to the core.

Parameters:
num_ports, 8, allocator dimension N (>=2); cell (i,j) = input i, output j, flat index i*N+j
skip_empty_diags, 0, 1 = next diagonal is the next one holding a request; 0 = plain rotate by one
starve_limit, 15, consecutive ungranted updates before a requesting diagonal is forced (1..255)
cnt_width, clogb(starve_limit+1), width of each per-diagonal age counter (derived; do not override)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
active  input  1  clock-enable; no state changes when 0
update  input  1  allocation result committed this cycle; advance priority
req  input  N*N  combined request matrix, index [0:N*N-1]
gnt  input  N*N  combined grant matrix from allocator, same cycle as req
prio_diag  output  N  one-hot priority diagonal, registered
diag_req  output  N  diagonal d has >=1 request (combinational)
starve_force  output  1  registered; 1 when the current prio_diag was chosen by starvation override
starve_any  output  1  combinational; some age counter equals starve_limit

Behaviour:
- Diagonal membership: cell (i,j) is on diagonal d = (i+j) mod N. diag_req[d] = OR of req on d; diag_gnt[d] = OR of gnt on d (internal).
- Reset (reset=0, async, takes effect mid-cycle) sets:
  - prio_diag = 1 at bit 0, all others 0;
  - all age counters = 0;
  - starve_force = 0.
  - Release is synchronous to clk.
- Commit event: commit = active & update. With no commit, all registers hold. An update while active=0 is ignored and is not remembered.
- Age counter per diagonal d, evaluated on commit only:
  - diag_req[d] & ~diag_gnt[d]: increment, saturating at starve_limit.
  - Otherwise: clear to 0.
- Next diagonal on commit. Let c = current index. The first matching rule wins:
  1. Starvation. Search circularly from c+1 through c (current last) for a diagonal whose counter, before this commit's increment, equals starve_limit. Select the first hit and set starve_force = 1.
  2. If skip_empty_diags = 1 and any diag_req bit is set: circular search from c+1 through c for a set diag_req bit. If only c has requests, prio_diag holds at c. starve_force = 0.
  3. Otherwise (including all-empty with skip on): rotate to (c+1) mod N. starve_force = 0.
- Latency: prio_diag, starve_force and the counters change on the clk edge that samples commit. Outputs are visible the following cycle. diag_req and starve_any are zero-latency.
- Invariants:
  - prio_diag is always exactly one-hot.
  - Counters never exceed starve_limit.
  - A forced diagonal with requests is granted on its next commit, because every requesting cell on the priority diagonal wins. Its counter then clears.
- Wrap-around: index N-1 advances to 0. Searches use modular arithmetic only.
- req/gnt containing X while active = 0 must not corrupt state.

Test Plan:
- Reset with N=4, then 4 commits, skip=0, no requests -> prio_diag 1000, 0100, 0010, 0001, 1000; starve_force stays 0.
- skip=1, N=4, prio=diag0, requests only at cell (1,2) (diag 3) -> one commit gives prio_diag=0001. Further commits hold at 0001 while only diag 3 requests.
- Commit with active=0 and update=1 for 5 cycles -> prio_diag and counters unchanged. Next commit with active=1 advances exactly one step.
- starve_limit=3, N=4, skip=0: diag 2 requests and is never granted.
  - After 3 commits, its counter is 3 and starve_any=1.
  - The 4th commit gives prio_diag=0010 and starve_force=1.
  - Then grant diag 2 -> counter 0; next commit rotates to 0001 with starve_force=0.
- Diags 1 and 3 both saturated, current c=2 -> next prio_diag=0001 (diag 3, first circularly after c). Following commit with diag 1 still saturated -> 0100.
- Assert reset=0 asynchronously between clk edges while prio_diag=0010 and counters are nonzero -> prio_diag=1000, counters 0 and starve_force=0 immediately, without waiting for a clock edge.
